alu_cmd_queue: RTL
==================

Name: alu_cmd_queue

Overview:
Command buffer directly upstream of the 2-stage ALU. Accepts operand/opcode commands from a producer over a valid/ready handshake, stores up to DEPTH entries, and issues them to the ALU's valid_i/data_i_1/data_i_2/sel_i inputs. The ALU has no backpressure, so issue is governed only by queue occupancy and an issue-enable input. Output fields are registered and drive the ALU inputs directly.

Parameters:
DATA_WIDTH, 8, operand width; matches the ALU's DATA_WIDTH.
SEL_WIDTH, 2, opcode width; matches the ALU's SEL_WIDTH.
DEPTH, 4, entry count; power of two, >= 2. ADDR_WIDTH = $clog2(DEPTH) is an internal localparam.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
valid_i  in  1  producer has a command.
ready_o  out  1  queue can accept; ready_o = !full && !rst (combinational).
data_i_1  in  DATA_WIDTH  operand 1.
data_i_2  in  DATA_WIDTH  operand 2.
sel_i  in  SEL_WIDTH  opcode.
en_i  in  1  issue enable; 0 holds the queue contents.
flush_i  in  1  discard all stored commands.
valid_o  out  1  one-cycle issue strobe to the ALU's valid_i.
data_o_1  out  DATA_WIDTH  issued operand 1.
data_o_2  out  DATA_WIDTH  issued operand 2.
sel_o  out  SEL_WIDTH  issued opcode.
count_o  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
full_o  out  1  count_o == DEPTH.
empty_o  out  1  count_o == 0.

Behaviour:
- Reset (rst=1 at an edge): write/read pointers 0, count 0, valid_o 0, data_o_1/data_o_2/sel_o 0. Stored entries are discarded. ready_o is 0 while rst is high. A reset asserted mid-stream drops all pending commands; no issue occurs in the reset cycle.
- Push: at an edge where valid_i && ready_o, store {data_i_1, data_i_2, sel_i} at the write pointer and increment it. Pointers wrap modulo DEPTH.
- Pop/issue: at an edge where en_i && !empty && !flush_i, load the head entry into data_o_1/data_o_2/sel_o, set valid_o=1, and increment the read pointer. Otherwise set valid_o=0; data_o_1/data_o_2/sel_o hold their last values.
- Latency: a command accepted at edge k has valid_o high in the cycle after edge k+1 at the earliest (one edge from accept to issue). There is no same-cycle bypass from input to output, including when the queue is empty.
- Throughput: one push and one pop per cycle. With en_i held high, there is a steady-state issue every cycle.
- Count updates at each edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Full: ready_o=0, so no push is possible even if a pop occurs in the same cycle; push-through-full is not supported.
- Empty: no pop. valid_o=0 at the next edge regardless of en_i.
- Flush: takes priority over push and pop in the same cycle. Pointers and count are cleared, valid_o=0 at that edge, and the concurrent push is dropped. ready_o is not gated by flush_i.
- Opcodes: all values, including unused 2'b11, are stored and issued unmodified. Decode is the ALU's job.
- Command order is strict FIFO.

Optional Feature:
Macro ALU_CMD_QUEUE_CNT_EN.
- Defined: adds output port issued_cnt_o [15:0], a count of valid_o pulses. It increments at each issue, wraps from 16'hFFFF to 0, is cleared by rst, and is not cleared by flush_i.
- Undefined: the port and the counter logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then push {8'h05, 8'h03, 2'b00} at edge 1 with en_i=1 -> valid_o=1 after edge 2 with data_o_1=05, data_o_2=03, sel_o=00; valid_o=0 after edge 3; count_o returns to 0.
2. en_i=0, push 4 commands (A0..A3) -> full_o=1, ready_o=0, count_o=4; a 5th valid_i is not accepted. Then set en_i=1 -> four consecutive valid_o pulses issuing A0, A1, A2, A3 in order.
3. en_i=1, valid_i high for 10 cycles with incrementing operands -> count_o stays at 1 after the first push, with one issue per cycle in order. This exercises pointer wrap past DEPTH.
4. Queue holds 3 entries; assert flush_i together with valid_i and en_i -> valid_o=0 at the next edge, count_o=0, empty_o=1, and the concurrent push is dropped.
5. Queue holds 2 entries with en_i=1; assert rst for 1 cycle -> valid_o=0, data_o_*=0, count_o=0, ready_o=0 during reset. No further issues occur until a new push.
6. With ALU_CMD_QUEUE_CNT_EN defined, issue 5 commands, flush, then issue 2 more -> issued_cnt_o=7. Apply rst -> issued_cnt_o=0.

Source files
------------

// File: rtl/alu_cmd_queue_if.sv
// Command/issue bundle between a producer, alu_cmd_queue and the downstream ALU.
// issued_cnt_o exists only when ALU_CMD_QUEUE_CNT_EN is defined.
interface alu_cmd_queue_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int DEPTH      = 4
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] data_i_1;
  logic [DATA_WIDTH-1:0] data_i_2;
  logic [SEL_WIDTH-1:0]  sel_i;
  logic                  en_i;
  logic                  flush_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o_1;
  logic [DATA_WIDTH-1:0] data_o_2;
  logic [SEL_WIDTH-1:0]  sel_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  full_o;
  logic                  empty_o;
`ifdef ALU_CMD_QUEUE_CNT_EN
  logic [15:0]           issued_cnt_o;
`endif

  modport slave (
    input  valid_i, data_i_1, data_i_2, sel_i, en_i, flush_i,
    output ready_o, valid_o, data_o_1, data_o_2, sel_o, count_o, full_o, empty_o
`ifdef ALU_CMD_QUEUE_CNT_EN
    , output issued_cnt_o
`endif
  );

  modport master (
    output valid_i, data_i_1, data_i_2, sel_i, en_i, flush_i,
    input  ready_o, valid_o, data_o_1, data_o_2, sel_o, count_o, full_o, empty_o
`ifdef ALU_CMD_QUEUE_CNT_EN
    , input issued_cnt_o
`endif
  );
endinterface

// File: rtl/alu_cmd_queue.sv
// DEPTH-entry FIFO of ALU commands with registered issue outputs; no input-to-output bypass.
// Optional issue counter (issued_cnt_o) enabled by defining ALU_CMD_QUEUE_CNT_EN.
module alu_cmd_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 2,
  parameter int DEPTH      = 4
) (
  input  logic          clk,
  input  logic          rst,
  alu_cmd_queue_if.slave q
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int ENTRY_W    = 2 * DATA_WIDTH + SEL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  ready;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    head;

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] d1_p0;
  logic [DATA_WIDTH-1:0] d2_p0;
  logic [SEL_WIDTH-1:0]  sel_p0;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // Flush does not gate ready; a flushed push is simply discarded below.
  assign ready = !full && !rst;
  assign push  = q.valid_i && ready && !q.flush_i;
  assign pop   = q.en_i && !empty && !q.flush_i && !rst;
  assign head  = mem[rd_ptr];

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {q.data_i_1, q.data_i_2, q.sel_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || q.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      vld_p0 <= pop;
    end
  end

  // Issue stage: operands hold between issues, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_p0  <= '0;
      d2_p0  <= '0;
      sel_p0 <= '0;
    end else if (pop) begin
      {d1_p0, d2_p0, sel_p0} <= head;
    end
  end

`ifdef ALU_CMD_QUEUE_CNT_EN
  logic [15:0] issued_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt <= '0;
    end else if (pop) begin
      issued_cnt <= issued_cnt + 16'd1;
    end
  end

  assign q.issued_cnt_o = issued_cnt;
`endif

  assign q.ready_o  = ready;
  assign q.valid_o  = vld_p0;
  assign q.data_o_1 = d1_p0;
  assign q.data_o_2 = d2_p0;
  assign q.sel_o    = sel_p0;
  assign q.count_o  = count;
  assign q.full_o   = full;
  assign q.empty_o  = empty;
endmodule
